restoring_divider_nb: RTL and testbench

//  Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU instructions; the inverse of the ALU add path.

---
 rtl/restoring_divider_nb_pkg.sv | 14 +
 rtl/restoring_divider_nb_rca.sv | 29 ++
 rtl/restoring_divider_nb.sv | 119 +++++++++++
 tb/tb_restoring_divider_nb.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_nb_pkg.sv
// Shared opcode and state encodings for the RV32M restoring divider.
package restoring_divider_nb_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/restoring_divider_nb_rca.sv
// Ripple-carry adder with optional operand-B inversion for the divider's trial subtract.
module ripple_carry_adder_Nb #(
  parameter int unsigned N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         inv_b_i,
  input  logic         carry_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);

  logic [N:0]   c;
  logic [N-1:0] b_eff;

  // Inverting B also injects the +1, so inv_b_i=1/carry_i=0 yields a - b.
  always_comb begin
    b_eff = b_i ^ {N{inv_b_i}};
    c     = '0;
    sum_o = '0;
    c[0]  = carry_i ^ inv_b_i;
    for (int i = 0; i < int'(N); i++) begin
      sum_o[i] = a_i[i] ^ b_eff[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_eff[i]) | (c[i] & (a_i[i] ^ b_eff[i]));
    end
    carry_o = c[N];
  end

endmodule

// File: rtl/restoring_divider_nb.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
module restoring_divider_nb
  import restoring_divider_nb_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] opa_i,
  input  logic [N-1:0] opb_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [N-1:0] res_o
);

  localparam int unsigned CW = $clog2(N);

  logic [1:0]   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0] p_q, q_q, d_q;
  logic         rem_q, neg_q_q, neg_r_q;

  logic         accept_c, signed_in_c, div_zero_c, ovf_c, special_c;
  logic [N-1:0] abs_a_c, abs_b_c, special_res_c;
  logic [N:0]   p_shift_c, t_sum_c;
  logic         carry_c, no_borrow_c;
  logic [N-1:0] q_fin_c, r_fin_c, sign_res_c;

  // Accept decode, special-case detection and next state.
  always_comb begin
    accept_c    = start_i && ready_o;
    signed_in_c = ~op_i[0];
    div_zero_c  = (opb_i == '0);
    ovf_c       = signed_in_c && (opa_i == {1'b1, {(N-1){1'b0}}}) && (opb_i == '1);
    special_c   = div_zero_c || ovf_c;
    state_d     = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_c) state_d = special_c ? S_DONE : S_CALC;
        else          state_d = S_IDLE;
      end
      S_CALC:  if (cnt_q == '0) state_d = S_SIGN;
      S_SIGN:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand magnitudes and RISC-V special results computed straight from the request.
  always_comb begin
    abs_a_c = (signed_in_c && opa_i[N-1]) ? (~opa_i + N'(1)) : opa_i;
    abs_b_c = (signed_in_c && opb_i[N-1]) ? (~opb_i + N'(1)) : opb_i;
    if (div_zero_c) special_res_c = op_i[1] ? opa_i : '1;
    else            special_res_c = op_i[1] ? '0 : opa_i;
  end

  assign p_shift_c = {p_q, q_q[N-1]};

  ripple_carry_adder_Nb #(.N(N+1)) u_rca (
    .a_i     (p_shift_c),
    .b_i     ({1'b0, d_q}),
    .inv_b_i (1'b1),
    .carry_i (1'b0),
    .sum_o   (t_sum_c),
    .carry_o (carry_c)
  );

  // A successful trial leaves a partial remainder below the divisor, so bit N is always clear.
  assign no_borrow_c = carry_c & ~t_sum_c[N];

  always_comb begin
    q_fin_c    = neg_q_q ? (~q_q + N'(1)) : q_q;
    r_fin_c    = neg_r_q ? (~p_q + N'(1)) : p_q;
    sign_res_c = rem_q ? r_fin_c : q_fin_c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      res_o   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      rem_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_o <= (state_d == S_IDLE) || (state_d == S_DONE);
      valid_o <= (state_d == S_DONE);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_c) begin
            p_q     <= '0;
            q_q     <= abs_a_c;
            d_q     <= abs_b_c;
            cnt_q   <= CW'(N - 1);
            rem_q   <= op_i[1];
            neg_q_q <= signed_in_c && (opa_i[N-1] ^ opb_i[N-1]);
            neg_r_q <= signed_in_c && opa_i[N-1];
            if (special_c) res_o <= special_res_c;
          end
        end
        S_CALC: begin
          p_q   <= no_borrow_c ? t_sum_c[N-1:0] : p_shift_c[N-1:0];
          q_q   <= {q_q[N-2:0], no_borrow_c};
          cnt_q <= cnt_q - CW'(1);
        end
        S_SIGN:  res_o <= sign_res_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_nb.sv
// Directed-vector and reference-model bench for restoring_divider_nb.
module tb_restoring_divider_nb;
  import restoring_divider_nb_pkg::*;

  localparam int unsigned N  = 32;
  localparam int          LN = N + 2;
  localparam int          LS = 1;

  logic         clk_i = 1'b0;
  logic         rst_i, start_i;
  logic [1:0]   op_i;
  logic [N-1:0] opa_i, opb_i;
  logic         ready_o, valid_o;
  logic [N-1:0] res_o;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  restoring_divider_nb #(.N(N)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .opa_i   (opa_i),
    .opb_i   (opb_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .res_o   (res_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk_i);
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!valid_o && lat < 100);
  endtask

  function automatic logic [N-1:0] ref_div(input logic [1:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    logic [N-1:0] q, r;
    longint sa, sb;
    if (b == '0) begin
      q = '1; r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == '1) begin
      q = a; r = '0;
    end else if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = N'(sa / sb);
      r  = N'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0 || (!op[0] && a == 32'h8000_0000 && b == '1)) return LS;
    return LN;
  endfunction

  initial begin
    int lat, lat2;
    logic late;
    logic [N-1:0] held, ra, rb;
    logic [1:0]   rop;

    rst_i = 1'b1; start_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_ready", N'(ready_o), 32'd1);
    check("reset_valid", N'(valid_o), 32'd0);
    check("reset_res",   res_o,       32'd0);

    vecs.push_back('{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         LN});
    vecs.push_back('{DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          LN});
    vecs.push_back('{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  LN});
    vecs.push_back('{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  LN});
    vecs.push_back('{DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  LN});
    vecs.push_back('{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          LN});
    vecs.push_back('{DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  LS});
    vecs.push_back('{DIV_OP_REM,  32'd5,          32'd0,          32'd5,          LS});
    vecs.push_back('{DIV_OP_DIV,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  LS});
    vecs.push_back('{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  LS});
    vecs.push_back('{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LS});
    vecs.push_back('{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LN});
    vecs.push_back('{DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  LN});
    vecs.push_back('{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  LN});
    vecs.push_back('{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  LN});
    vecs.push_back('{DIV_OP_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          LN});
    vecs.push_back('{DIV_OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         LN});
    vecs.push_back('{DIV_OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  LN});
    vecs.push_back('{DIV_OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  LN});
    vecs.push_back('{DIV_OP_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  LN});
    vecs.push_back('{DIV_OP_DIV,  32'd0,          32'hFFFF_FFFD,  32'd0,          LN});
    vecs.push_back('{DIV_OP_DIVU, 32'd3,          32'd5,          32'd0,          LN});
    vecs.push_back('{DIV_OP_REMU, 32'd3,          32'd5,          32'd3,          LN});

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check($sformatf("vec%0d_res", i), res_o, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), N'(lat), N'(vecs[i].lat));
      @(negedge clk_i);
      check($sformatf("vec%0d_single_pulse", i), N'(valid_o), 32'd0);
      check($sformatf("vec%0d_hold", i), res_o, vecs[i].exp);
    end

    // Reset during CALC discards the in-flight result.
    issue(DIV_OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("midreset_ready", N'(ready_o), 32'd1);
    check("midreset_valid", N'(valid_o), 32'd0);
    check("midreset_res",   res_o,       32'd0);
    late = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) late = 1'b1;
    end
    check("midreset_no_late_valid", N'(late), 32'd0);
    issue(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_valid(lat);
    check("postreset_res", res_o, 32'hFFFF_FFFD);
    check("postreset_lat", N'(lat), N'(LN));

    // Back-to-back: start held into DONE, operands changed during CALC, stray pulse in CALC.
    @(negedge clk_i);
    op_i = DIV_OP_DIVU; opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
    @(posedge clk_i);
    #1 op_i = DIV_OP_REMU; opa_i = 32'd1000; opb_i = 32'd33;
    wait_valid(lat);
    check("b2b_first_res", res_o, 32'd14);
    check("b2b_first_lat", N'(lat), N'(LN));
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    op_i = DIV_OP_DIV; opa_i = 32'd9; opb_i = 32'd3; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_valid(lat2);
    check("b2b_second_res", res_o, 32'd10);
    check("b2b_second_lat", N'(5 + lat2), N'(LN));
    held = res_o;
    @(negedge clk_i);
    check("b2b_single_pulse", N'(valid_o), 32'd0);
    check("b2b_ready_after", N'(ready_o), 32'd1);
    check("b2b_hold", res_o, 32'd10);

    // Random operations against the reference model.
    for (int k = 0; k < 150; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 20)) : N'($urandom);
      if (k % 25 == 0) rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'd0;
      if (k % 25 == 0) ra = 32'h8000_0000;
      issue(rop, ra, rb);
      wait_valid(lat);
      check($sformatf("rand%0d_res op=%0d a=%08h b=%08h", k, rop, ra, rb), res_o, ref_div(rop, ra, rb));
      check($sformatf("rand%0d_lat", k), N'(lat), N'(ref_lat(rop, ra, rb)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
